sdram_req_arb: RTL and testbench

- Multi-channel request arbiter that merges NUM_CH_P client request streams onto one SDRAM-style cmd/addr/data bus, on the SDRAM agent side of the design.
- Successor to the single-channel SDRAM interface bundle: generalised channel count, valid/ready handshakes, round-robin fairness and bounded burst grants.
- Output is register-sliced; the downstream controller applies backpressure with out_ready.

---
 rtl/sdram_req_arb.sv | 139 +++++++++++++
 tb/tb_sdram_req_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arb.sv
// sdram_req_arb: round-robin arbiter merging NUM_CH_P valid/ready request streams onto one
// register-sliced SDRAM cmd/addr/data bus. Define SDRAM_ARB_CH0_PRIO_EN for channel-0 priority.
module sdram_req_arb #(
  parameter int DATA_SZ_P   = 32,
  parameter int ADDR_SZ_P   = 10,
  parameter int NUM_CH_P    = 4,
  parameter int BURST_LEN_P = 4,
  localparam int CH_W = (NUM_CH_P > 1) ? $clog2(NUM_CH_P) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH_P-1:0]           ch_valid,
  output logic [NUM_CH_P-1:0]           ch_ready,
  input  logic [NUM_CH_P-1:0]           ch_cmd,
  input  logic [NUM_CH_P*ADDR_SZ_P-1:0] ch_addr,
  input  logic [NUM_CH_P*DATA_SZ_P-1:0] ch_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_cmd,
  output logic [ADDR_SZ_P-1:0]          out_addr,
  output logic [DATA_SZ_P-1:0]          out_data,
  output logic [CH_W-1:0]               out_ch
);

  localparam int CNT_W = $clog2(BURST_LEN_P + 1);
  localparam int IDX_W = CH_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN_P - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH_P - 1);
  localparam logic [IDX_W-1:0] NUM_CH_W  = IDX_W'(NUM_CH_P);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_reg;
  logic [CH_W-1:0]      grant_reg;
  logic [CH_W-1:0]      rr_ptr_reg;
  logic                 burst_cmd_reg;
  logic [CNT_W-1:0]     beat_cnt_reg;

  logic [ADDR_SZ_P-1:0] addr_arr [NUM_CH_P];
  logic [DATA_SZ_P-1:0] data_arr [NUM_CH_P];

  logic                 can_load;
  logic                 grant_valid;
  logic                 cmd_match;
  logic                 accept;
  logic                 burst_done;
  logic [CH_W-1:0]      next_rr;
  logic                 sel_found;
  logic [CH_W-1:0]      sel_ch;
  logic [IDX_W-1:0]     idx;

  assign can_load    = !out_valid || out_ready;
  assign grant_valid = ch_valid[grant_reg];
  assign cmd_match   = (ch_cmd[grant_reg] == burst_cmd_reg);
  assign accept      = (state_reg == BURST) && grant_valid && cmd_match && can_load;
  // A stalled beat neither counts nor ends the burst; a drop of valid or a command change does.
  assign burst_done  = (state_reg == BURST) &&
                       (!grant_valid || !cmd_match || (accept && beat_cnt_reg == LAST_BEAT));
  assign next_rr     = (grant_reg == LAST_CH) ? '0 : grant_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH_P; gi++) begin : g_ch
      assign addr_arr[gi] = ch_addr[gi*ADDR_SZ_P +: ADDR_SZ_P];
      assign data_arr[gi] = ch_data[gi*DATA_SZ_P +: DATA_SZ_P];
      assign ch_ready[gi] = accept && (grant_reg == CH_W'(gi));
    end
  endgenerate

  // First requesting channel at or after rr_ptr, wrapping without a power-of-two assumption.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH_P; k++) begin
      idx = {1'b0, rr_ptr_reg} + IDX_W'(k);
      if (idx >= NUM_CH_W) idx = idx - NUM_CH_W;
      if (!sel_found && ch_valid[idx[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = idx[CH_W-1:0];
      end
    end
`ifdef SDRAM_ARB_CH0_PRIO_EN
    if (ch_valid[0]) begin
      sel_found = 1'b1;
      sel_ch    = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cmd_reg <= 1'b0;
      beat_cnt_reg  <= '0;
      out_valid     <= 1'b0;
      out_cmd       <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      out_ch        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            state_reg     <= BURST;
            grant_reg     <= sel_ch;
            burst_cmd_reg <= ch_cmd[sel_ch];
            beat_cnt_reg  <= '0;
          end
        end
        BURST: begin
          if (accept) beat_cnt_reg <= beat_cnt_reg + 1'b1;
          if (burst_done) begin
            state_reg <= IDLE;
`ifdef SDRAM_ARB_CH0_PRIO_EN
            if (grant_reg != '0) rr_ptr_reg <= next_rr;
`else
            rr_ptr_reg <= next_rr;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (accept) begin
        out_valid <= 1'b1;
        out_cmd   <= burst_cmd_reg;
        out_addr  <= addr_arr[grant_reg];
        out_data  <= data_arr[grant_reg];
        out_ch    <= grant_reg;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed testbench for sdram_req_arb: per-channel source queues, per-cycle snapshots,
// and hand-computed beat/accept timing for each scenario.
module tb_sdram_req_arb;
  localparam int DW = 32, AW = 10, NCH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   ch_valid, ch_ready, ch_cmd;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic             out_valid, out_ready, out_cmd;
  logic [AW-1:0]    out_addr;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_ch;

  sdram_req_arb #(.DATA_SZ_P(DW), .ADDR_SZ_P(AW), .NUM_CH_P(NCH), .BURST_LEN_P(4)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_cmd(ch_cmd),
    .ch_addr(ch_addr), .ch_data(ch_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_cmd(out_cmd), .out_addr(out_addr), .out_data(out_data), .out_ch(out_ch));

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0;

  logic [AW-1:0] src_addr [NCH][16];
  logic          src_cmd  [NCH][16];
  int            src_len  [NCH];
  int            src_pos  [NCH];

  int            n_beats, n_acc, cyc;
  logic [1:0]    b_ch [64];
  logic [AW-1:0] b_addr [64];
  logic          b_cmd [64];
  logic [DW-1:0] b_data [64];
  int            b_cyc [64];
  int            a_cyc [64];
  logic          cyc_ov [64];
  logic [NCH-1:0] cyc_rdy [64];
  logic [AW-1:0] cyc_oaddr [64];
  logic [1:0]    cyc_och [64];
  logic          stall [64];

  function automatic logic [DW-1:0] mkdata(input int ch, input logic [AW-1:0] a);
    return 32'hD000_0000 | (DW'(ch) << 16) | DW'(a);
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NCH; i++) begin src_len[i] = 0; src_pos[i] = 0; end
    for (int c = 0; c < 64; c++) stall[c] = 1'b0;
    n_beats = 0; n_acc = 0; cyc = 0;
    ch_valid = '0; ch_cmd = '0; ch_addr = '0; ch_data = '0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input int ch, input int n, input logic [AW-1:0] base, input logic cmd);
    for (int j = 0; j < n; j++) begin
      src_addr[ch][j] = base + AW'(j);
      src_cmd[ch][j]  = cmd;
    end
    src_len[ch] = n;
    src_pos[ch] = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    for (int i = 0; i < NCH; i++) begin
      if (src_pos[i] < src_len[i]) begin
        ch_valid[i] = 1'b1;
        ch_cmd[i]   = src_cmd[i][src_pos[i]];
        ch_addr[i*AW +: AW] = src_addr[i][src_pos[i]];
        ch_data[i*DW +: DW] = mkdata(i, src_addr[i][src_pos[i]]);
      end else begin
        ch_valid[i] = 1'b0;
        ch_cmd[i]   = 1'b0;
        ch_addr[i*AW +: AW] = '0;
        ch_data[i*DW +: DW] = '0;
      end
    end
    out_ready = !stall[cyc];
    #1;
    cyc_ov[cyc] = out_valid; cyc_rdy[cyc] = ch_ready;
    cyc_oaddr[cyc] = out_addr; cyc_och[cyc] = out_ch;
    if (out_valid && out_ready && n_beats < 64) begin
      b_ch[n_beats] = out_ch; b_addr[n_beats] = out_addr; b_cmd[n_beats] = out_cmd;
      b_data[n_beats] = out_data; b_cyc[n_beats] = cyc;
      n_beats++;
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_ready[i] && n_acc < 64) begin
        a_cyc[n_acc] = cyc;
        n_acc++;
        src_pos[i]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (cyc < 63) cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_all();
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_cmd !== 1'b0 || out_addr !== '0 || out_data !== '0 ||
        out_ch !== '0 || ch_ready !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: got v=%b c=%b a=%h d=%h ch=%0d rdy=%b want all 0",
               out_valid, out_cmd, out_addr, out_data, out_ch, ch_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) step();
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (cyc_ov[c] !== 1'b0 || cyc_rdy[c] !== '0 || cyc_och[c] !== '0) begin
        tests_failed++;
        $display("FAIL idle_quiet[%0d]: got v=%b rdy=%b ch=%0d want 0/0000/0",
                 c, cyc_ov[c], cyc_rdy[c], cyc_och[c]);
      end
    end
  endtask

  task automatic test_stream();
    int exp_acc [6] = '{1, 2, 3, 4, 6, 7};
    do_reset();
    load(0, 6, 10'h010, 1'b1);
    repeat (12) step();
    tests_run++;
    if (n_beats !== 6) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d beats want 6", n_beats);
    end
    tests_run++;
    if (cyc_rdy[5] !== '0) begin
      tests_failed++;
      $display("FAIL stream_gap: got ch_ready=%b in cycle 5 want 0000", cyc_rdy[5]);
    end
    for (int j = 0; j < 6 && j < n_beats; j++) begin
      tests_run++;
      if (b_addr[j] !== 10'h010 + AW'(j) || b_cmd[j] !== 1'b1 || b_ch[j] !== 2'd0 ||
          b_data[j] !== mkdata(0, 10'h010 + AW'(j)) || a_cyc[j] !== exp_acc[j] ||
          b_cyc[j] !== exp_acc[j] + 1) begin
        tests_failed++;
        $display("FAIL stream_beat[%0d]: got a=%h c=%b ch=%0d d=%h acc@%0d out@%0d want a=%h c=1 ch=0 acc@%0d out@%0d",
                 j, b_addr[j], b_cmd[j], b_ch[j], b_data[j], a_cyc[j], b_cyc[j],
                 10'h010 + AW'(j), exp_acc[j], exp_acc[j] + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NCH; i++) load(i, 8, AW'(i * 'h40), (i % 2) == 0);
    repeat (28) step();
    tests_run++;
    if (n_beats < 20) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d beats want >= 20", n_beats);
    end
    for (int k = 0; k < 20 && k < n_beats; k++) begin
      int ech, eidx, ecyc;
      ech  = (k / 4) % 4;
      eidx = (k >= 16) ? 4 + (k % 4) : (k % 4);
      ecyc = 2 + (k / 4) * 5 + (k % 4);
      tests_run++;
      if (b_ch[k] !== 2'(ech) || b_addr[k] !== AW'(ech * 'h40 + eidx) ||
          b_cmd[k] !== ((ech % 2) == 0) || b_cyc[k] !== ecyc) begin
        tests_failed++;
        $display("FAIL rr_beat[%0d]: got ch=%0d a=%h c=%b @%0d want ch=%0d a=%h @%0d",
                 k, b_ch[k], b_addr[k], b_cmd[k], b_cyc[k], ech, ech * 'h40 + eidx, ecyc);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_acc [6] = '{1, 5, 6, 7, 9, 10};
    do_reset();
    load(1, 6, 10'h080, 1'b0);
    for (int c = 2; c <= 4; c++) stall[c] = 1'b1;
    repeat (14) step();
    for (int c = 2; c <= 4; c++) begin
      tests_run++;
      if (cyc_ov[c] !== 1'b1 || cyc_oaddr[c] !== 10'h080 || cyc_och[c] !== 2'd1 ||
          cyc_rdy[c] !== '0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%b a=%h ch=%0d rdy=%b want 1/080/1/0000",
                 c, cyc_ov[c], cyc_oaddr[c], cyc_och[c], cyc_rdy[c]);
      end
    end
    tests_run++;
    if (n_beats !== 6) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats want 6", n_beats);
    end
    for (int j = 0; j < 6 && j < n_beats && j < n_acc; j++) begin
      tests_run++;
      if (b_addr[j] !== 10'h080 + AW'(j) || b_ch[j] !== 2'd1 || b_cmd[j] !== 1'b0 ||
          a_cyc[j] !== exp_acc[j]) begin
        tests_failed++;
        $display("FAIL bp_beat[%0d]: got a=%h ch=%0d acc@%0d want a=%h ch=1 acc@%0d",
                 j, b_addr[j], b_ch[j], a_cyc[j], 10'h080 + AW'(j), exp_acc[j]);
      end
    end
  endtask

  task automatic test_cmd_switch();
    int exp_cyc [3] = '{2, 3, 6};
    do_reset();
    load(2, 3, 10'h100, 1'b0);
    src_cmd[2][2] = 1'b1;
    repeat (9) step();
    tests_run++;
    if (n_beats !== 3 || cyc_rdy[3] !== '0) begin
      tests_failed++;
      $display("FAIL cmd_count: got %0d beats rdy@3=%b want 3 beats rdy@3=0000", n_beats, cyc_rdy[3]);
    end
    for (int j = 0; j < 3 && j < n_beats; j++) begin
      tests_run++;
      if (b_addr[j] !== 10'h100 + AW'(j) || b_cmd[j] !== (j == 2) || b_ch[j] !== 2'd2 ||
          b_cyc[j] !== exp_cyc[j]) begin
        tests_failed++;
        $display("FAIL cmd_beat[%0d]: got a=%h c=%b ch=%0d @%0d want a=%h c=%0d ch=2 @%0d",
                 j, b_addr[j], b_cmd[j], b_ch[j], b_cyc[j], 10'h100 + AW'(j), j == 2, exp_cyc[j]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load(2, 4, 10'h0C0, 1'b1);
    repeat (6) step();
    load(1, 4, 10'h050, 1'b1);
    repeat (3) step();
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_addr !== 10'h051) begin
      tests_failed++;
      $display("FAIL midrst_pre: got v=%b ch=%0d a=%h want 1/1/051", out_valid, out_ch, out_addr);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_addr !== '0 || out_ch !== '0 || ch_ready !== '0) begin
      tests_failed++;
      $display("FAIL midrst_abort: got v=%b a=%h ch=%0d rdy=%b want all 0",
               out_valid, out_addr, out_ch, ch_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_all();
    load(1, 4, 10'h060, 1'b0);
    load(3, 4, 10'h070, 1'b0);
    repeat (7) step();
    tests_run++;
    if (n_beats < 1 || b_ch[0] !== 2'd1 || b_addr[0] !== 10'h060 || a_cyc[0] !== 1) begin
      tests_failed++;
      $display("FAIL midrst_rrptr: got beats=%0d ch=%0d a=%h acc@%0d want ch=1 a=060 acc@1",
               n_beats, b_ch[0], b_addr[0], a_cyc[0]);
    end
  endtask

  task automatic test_ch0_prio();
    do_reset();
    load(0, 8, 10'h000, 1'b1);
    load(3, 8, 10'h300, 1'b1);
    repeat (22) step();
    tests_run++;
    if (n_beats < 16) begin
      tests_failed++;
      $display("FAIL prio_count: got %0d beats want >= 16", n_beats);
    end
    for (int k = 0; k < 16 && k < n_beats; k++) begin
      int ech;
`ifdef SDRAM_ARB_CH0_PRIO_EN
      ech = (k < 8) ? 0 : 3;
`else
      ech = ((k / 4) % 2 == 0) ? 0 : 3;
`endif
      tests_run++;
      if (b_ch[k] !== 2'(ech)) begin
        tests_failed++;
        $display("FAIL prio_beat[%0d]: got ch=%0d want ch=%0d", k, b_ch[k], ech);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_round_robin();
    test_backpressure();
    test_cmd_switch();
    test_reset_mid_burst();
    test_ch0_prio();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
